// File: rtl/sobel_pkg.sv
// Shared types for the Sobel scan controller: pixel/window types, scan states
// and the neighbour-offset to window-index mapping.
package sobel_pkg;

    typedef logic [7:0] pixel_t;
    typedef pixel_t [2:0][2:0] window_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_FULL = 3'd1,
        LOAD_COL  = 3'd2,
        CALC      = 3'd3,
        EMIT      = 3'd4,
        DONE      = 3'd5
    } scan_state_t;

    // Offset (i,j) from the window's top-left pixel -> {row_idx, col_idx}
    function automatic logic [3:0] window_idx(input logic [1:0] i, input logic [1:0] j);
        return {2'd2 - i, 2'd2 - j};
    endfunction

endpackage

// File: rtl/sobel_scan_ctrl_if.sv
// Pixel-memory read port and result stream of the Sobel scan controller.
interface sobel_scan_ctrl_if import sobel_pkg::*; #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) ();

    logic                      mem_read;
    logic [ADDR_W-1:0]         mem_addr;
    pixel_t                    mem_rdata;
    logic                      mem_rvalid;

    logic                      out_valid;
    logic                      out_ready;
    logic                      out_pixel;
    logic [$clog2(HEIGHT)-1:0] out_row;
    logic [$clog2(WIDTH)-1:0]  out_col;

    modport master (
        output mem_read, mem_addr, out_valid, out_pixel, out_row, out_col,
        input  mem_rdata, mem_rvalid, out_ready
    );

    modport slave (
        input  mem_read, mem_addr, out_valid, out_pixel, out_row, out_col,
        output mem_rdata, mem_rvalid, out_ready
    );

endinterface

// File: rtl/sobel_window_reg.sv
// 3x3 pixel window register: single-pixel load at an index and a one-column
// shift towards the high column index.
module sobel_window_reg import sobel_pkg::*; (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       load,
    input  logic       shift,
    input  logic [1:0] row_idx,
    input  logic [1:0] col_idx,
    input  pixel_t     din,
    output window_t    win
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            win <= '0;
        end else begin
            if (shift) begin
                for (int unsigned r = 0; r < 3; r++) begin
                    win[r][2] <= win[r][1];
                    win[r][1] <= win[r][0];
                end
            end
            if (load) begin
                win[row_idx][col_idx] <= din;
            end
        end
    end

endmodule

// File: rtl/sobel_scan_ctrl.sv
// Raster scan over the interior pixels of an image: fetches each 3x3 window
// (sliding by one column where possible), runs sobel_edge, streams edge bits.
module sobel_scan_ctrl import sobel_pkg::*; #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              sobel_en,
    output window_t           comp_matrix,
    input  logic              output_pixel,
    input  logic              sobel_done,
    sobel_scan_ctrl_if.master bus
);

    localparam int ROW_W = $clog2(HEIGHT);
    localparam int COL_W = $clog2(WIDTH);
    localparam logic [ROW_W-1:0] LAST_R = ROW_W'(HEIGHT - 2);
    localparam logic [COL_W-1:0] LAST_C = COL_W'(WIDTH - 2);

    scan_state_t       state;
    logic [ROW_W-1:0]  r;
    logic [COL_W-1:0]  c;
    logic [1:0]        li, lj;
    logic              pix_q;
    logic [ADDR_W-1:0] row_a, col_a;
    logic [3:0]        widx;
    logic              rd_ok, last_rd, accept;

    assign rd_ok   = bus.mem_read && bus.mem_rvalid;
    assign accept  = (state == EMIT) && bus.out_ready;
    assign last_rd = (li == 2'd2) && ((state == LOAD_COL) || (lj == 2'd2));

    // A column step only fetches the new right-hand column (offset j = 2)
    always_comb begin
        row_a = ADDR_W'(r) + ADDR_W'(li) - ADDR_W'(1);
        if (state == LOAD_COL) begin
            col_a = ADDR_W'(c) + ADDR_W'(1);
        end else begin
            col_a = ADDR_W'(c) + ADDR_W'(lj) - ADDR_W'(1);
        end
    end

    assign widx = window_idx(li, (state == LOAD_COL) ? 2'd2 : lj);

    assign bus.mem_read  = (state == LOAD_FULL) || (state == LOAD_COL);
    assign bus.mem_addr  = bus.mem_read ? (row_a * ADDR_W'(WIDTH) + col_a) : '0;
    assign sobel_en      = (state == CALC);
    assign bus.out_valid = (state == EMIT);
    assign bus.out_pixel = pix_q;
    assign bus.out_row   = r;
    assign bus.out_col   = c;
    assign done          = (state == DONE);
    assign busy          = (state == LOAD_FULL) || (state == LOAD_COL) ||
                           (state == CALC) || (state == EMIT);

    sobel_window_reg u_window (
        .clk     (clk),
        .n_rst   (n_rst),
        .load    (rd_ok),
        .shift   (accept && (c != LAST_C)),
        .row_idx (widx[3:2]),
        .col_idx (widx[1:0]),
        .din     (bus.mem_rdata),
        .win     (comp_matrix)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            r     <= '0;
            c     <= '0;
            li    <= '0;
            lj    <= '0;
            pix_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        r     <= ROW_W'(1);
                        c     <= COL_W'(1);
                        li    <= '0;
                        lj    <= '0;
                        state <= LOAD_FULL;
                    end
                end
                LOAD_FULL, LOAD_COL: begin
                    if (bus.mem_rvalid) begin
                        if (last_rd) begin
                            li    <= '0;
                            lj    <= '0;
                            state <= CALC;
                        end else if ((state == LOAD_COL) || (lj == 2'd2)) begin
                            li <= li + 2'd1;
                            lj <= '0;
                        end else begin
                            lj <= lj + 2'd1;
                        end
                    end
                end
                CALC: begin
                    if (sobel_done) begin
                        pix_q <= output_pixel;
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (c != LAST_C) begin
                            c     <= c + COL_W'(1);
                            state <= LOAD_COL;
                        end else if (r != LAST_R) begin
                            r     <= r + ROW_W'(1);
                            c     <= COL_W'(1);
                            state <= LOAD_FULL;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r     <= '0;
                    c     <= '0;
                    pix_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// Bench for sobel_scan_ctrl: a 3x3 and a 5x4 instance, each with a pixel
// memory model and a sobel_edge model, checked against an image-level model.
module tb_sobel_scan_ctrl;

    localparam int NCFG = 2;

    function automatic int cfg_w(input int g);
        return (g == 0) ? 3 : 5;
    endfunction

    function automatic int cfg_h(input int g);
        return (g == 0) ? 3 : 4;
    endfunction

    logic tb_clk = 1'b0;
    logic n_rst;
    logic [NCFG-1:0] start, ready;
    logic [NCFG-1:0] busy_w, done_w, rd_w, rv_w, en_w, ov_w, op_w;
    logic [NCFG-1:0][4:0] addr_w;
    logic [NCFG-1:0][3:0] row_w, col_w;
    logic [NCFG-1:0][2:0][2:0][7:0] cm_w;
    logic [7:0] img [NCFG][20];
    int unsigned rd_delay;
    logic spur_en;

    always #5 tb_clk = ~tb_clk;

    // Edge decision of the sobel_edge model; p[i][j] is in image orientation.
    function automatic logic edge_bit(input logic [2:0][2:0][7:0] p);
        int gx, gy;
        gx = int'(p[0][2]) + 2 * int'(p[1][2]) + int'(p[2][2])
           - int'(p[0][0]) - 2 * int'(p[1][0]) - int'(p[2][0]);
        gy = int'(p[2][0]) + 2 * int'(p[2][1]) + int'(p[2][2])
           - int'(p[0][0]) - 2 * int'(p[0][1]) - int'(p[0][2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return (gx + gy) > 128;
    endfunction

    for (genvar G = 0; G < NCFG; G++) begin : g_env
        localparam int W = (G == 0) ? 3 : 5;
        localparam int H = (G == 0) ? 3 : 4;

        sobel_scan_ctrl_if #(.WIDTH(W), .HEIGHT(H)) bus ();
        logic [2:0][2:0][7:0] cm, orient;
        logic s_en, s_done, s_pix;
        logic sd_q = 1'b0;
        int unsigned wcnt = 0;

        sobel_scan_ctrl #(.WIDTH(W), .HEIGHT(H)) u_dut (
            .clk          (tb_clk),
            .n_rst        (n_rst),
            .start        (start[G]),
            .busy         (busy_w[G]),
            .done         (done_w[G]),
            .sobel_en     (s_en),
            .comp_matrix  (cm),
            .output_pixel (s_pix),
            .sobel_done   (s_done),
            .bus          (bus)
        );

        assign bus.mem_rvalid = bus.mem_read ? (wcnt >= rd_delay) : spur_en;
        assign bus.mem_rdata  = img[G][int'(bus.mem_addr)];
        always @(posedge tb_clk) wcnt <= (bus.mem_read && !bus.mem_rvalid) ? wcnt + 1 : 0;

        always_comb begin
            orient = '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    orient[i][j] = cm[2-i][2-j];
        end
        assign s_pix  = edge_bit(orient);
        always @(posedge tb_clk) sd_q <= s_en && !sd_q;
        assign s_done = sd_q || (spur_en && !s_en);

        assign bus.out_ready = ready[G];
        assign rd_w[G]   = bus.mem_read;
        assign rv_w[G]   = bus.mem_rvalid;
        assign addr_w[G] = 5'(bus.mem_addr);
        assign en_w[G]   = s_en;
        assign cm_w[G]   = cm;
        assign ov_w[G]   = bus.out_valid;
        assign op_w[G]   = bus.out_pixel;
        assign row_w[G]  = 4'(bus.out_row);
        assign col_w[G]  = 4'(bus.out_col);
    end

    int compared = 0;
    int mismatched = 0;
    int cur = 0;
    int exp_rd[$];
    logic [8:0] exp_res[$];
    int rd_log[$];
    logic [8:0] res_log[$];
    logic [8:0] ref_log[$];
    int done_cnt = 0;
    logic [2:0][2:0][7:0] last_win = '0;
    logic prev_rd_wait = 1'b0, prev_stall = 1'b0, prev_done = 1'b0;
    logic [4:0] prev_addr = '0;
    logic [8:0] prev_out = '0;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Window of image g centred on (r,c), image orientation.
    function automatic logic [2:0][2:0][7:0] img_win(input int g, input int r, input int c);
        logic [2:0][2:0][7:0] w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[i][j] = img[g][(r - 1 + i) * cfg_w(g) + c - 1 + j];
        return w;
    endfunction

    // Same window in comp_matrix layout: [2-i][2-j] = pixel(r-1+i, c-1+j).
    function automatic logic [2:0][2:0][7:0] dut_win(input int g, input int r, input int c);
        logic [2:0][2:0][7:0] w, d;
        w = img_win(g, r, c);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                d[2-i][2-j] = w[i][j];
        return d;
    endfunction

    task automatic arm(input int g);
        int w, h;
        w = cfg_w(g);
        h = cfg_h(g);
        cur = g;
        exp_rd.delete(); exp_res.delete(); rd_log.delete(); res_log.delete();
        done_cnt = 0;
        prev_rd_wait = 1'b0; prev_stall = 1'b0; prev_done = 1'b0;
        for (int r = 1; r <= h - 2; r++) begin
            for (int c = 1; c <= w - 2; c++) begin
                if (c == 1) begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            exp_rd.push_back((r - 1 + i) * w + c - 1 + j);
                end else begin
                    for (int i = 0; i < 3; i++)
                        exp_rd.push_back((r - 1 + i) * w + c + 1);
                end
                exp_res.push_back({4'(r), 4'(c), edge_bit(img_win(g, r, c))});
            end
        end
    endtask

    // Checks the cycle whose inputs are already driven, then advances one clock.
    task automatic step();
        int g;
        logic [8:0] out, e;
        g = cur;
        #1;
        if (n_rst) begin
            out = {row_w[g], col_w[g], op_w[g]};
            if (rd_w[g] && prev_rd_wait) chk("addr_hold", addr_w[g], prev_addr);
            if (rd_w[g] && rv_w[g]) begin
                rd_log.push_back(addr_w[g]);
                if (exp_rd.size() == 0) chk("extra_read", addr_w[g], -1);
                else chk("read_addr", addr_w[g], exp_rd.pop_front());
            end
            prev_rd_wait = rd_w[g] && !rv_w[g];
            prev_addr = addr_w[g];
            if (en_w[g]) begin
                last_win = cm_w[g];
                if (exp_res.size() == 0) chk("extra_calc", 1, 0);
                else begin
                    e = exp_res[0];
                    chk("window", int'(cm_w[g] == dut_win(g, int'(e[8:5]), int'(e[4:1]))), 1);
                end
            end
            if (prev_stall) begin
                chk("valid_hold", ov_w[g], 1);
                chk("data_hold", out, prev_out);
            end
            if (ov_w[g] && !ready[g]) begin
                chk("stall_no_read", rd_w[g], 0);
                chk("stall_no_en", en_w[g], 0);
            end
            if (ov_w[g] && ready[g]) begin
                res_log.push_back(out);
                if (exp_res.size() == 0) chk("extra_result", out, -1);
                else chk("result", out, exp_res.pop_front());
            end
            prev_stall = ov_w[g] && !ready[g];
            prev_out = out;
            if (prev_done) chk("busy_after_done", busy_w[g], 0);
            if (done_w[g]) done_cnt++;
            prev_done = done_w[g];
        end
        @(negedge tb_clk);
    endtask

    task automatic kick(input int g);
        arm(g);
        start[g] = 1'b1;
        step();
        start[g] = 1'b0;
        chk("busy_after_start", busy_w[g], 1);
    endtask

    task automatic run_until_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        chk("scan_finished", done_cnt, 1);
        step();
        step();
        chk("done_once", done_cnt, 1);
        chk("queues_drained", exp_rd.size() + exp_res.size(), 0);
    endtask

    initial begin
        int n, k0;
        int er [6];
        logic [8:0] v;
        int grad [9];
        er = '{11, 12, 13, 21, 22, 23};
        grad = '{0, 156, 200, 0, 111, 234, 0, 123, 178};
        n_rst = 1'b0; start = '0; ready = '1; rd_delay = 0; spur_en = 1'b0;
        for (int g = 0; g < NCFG; g++)
            for (int a = 0; a < 20; a++) img[g][a] = '0;
        repeat (2) @(negedge tb_clk);
        for (int g = 0; g < NCFG; g++) begin
            chk("rst_busy", busy_w[g], 0);
            chk("rst_done", done_w[g], 0);
            chk("rst_mem_read", rd_w[g], 0);
            chk("rst_mem_addr", addr_w[g], 0);
            chk("rst_sobel_en", en_w[g], 0);
            chk("rst_comp_matrix", int'(cm_w[g] != '0), 0);
            chk("rst_out_valid", ov_w[g], 0);
            chk("rst_out_fields", {row_w[g], col_w[g], op_w[g]}, 0);
        end
        n_rst = 1'b1;
        @(negedge tb_clk);

        // 3x3 uniform image
        for (int a = 0; a < 9; a++) img[0][a] = 8'd1;
        kick(0);
        run_until_done(200);
        chk("t1_reads", rd_log.size(), 9);
        for (int k = 0; k < rd_log.size() && k < 9; k++) chk("t1_read_order", rd_log[k], k);
        chk("t1_results", res_log.size(), 1);
        if (res_log.size() > 0) chk("t1_result", res_log[0], {4'd1, 4'd1, 1'b0});

        // 3x3 strong horizontal gradient, with stray rvalid/sobel_done outside their phases
        for (int a = 0; a < 9; a++) img[0][a] = 8'(grad[a]);
        spur_en = 1'b1;
        kick(0);
        run_until_done(200);
        spur_en = 1'b0;
        chk("t2_win22", last_win[2][2], 0);
        chk("t2_win00", last_win[0][0], 178);
        chk("t2_results", res_log.size(), 1);
        if (res_log.size() > 0) begin
            v = res_log[0];
            chk("t2_pixel", v[0], 1);
        end

        // 5x4 uniform image, start pulsed again mid-scan
        for (int a = 0; a < 20; a++) img[1][a] = 8'd10;
        kick(1);
        repeat (4) step();
        start[1] = 1'b1;
        repeat (5) step();
        start[1] = 1'b0;
        run_until_done(400);
        chk("t3_reads", rd_log.size(), 30);
        chk("t3_results", res_log.size(), 6);
        for (int k = 0; k < 6 && k < res_log.size(); k++) begin
            v = res_log[k];
            chk("t3_row", v[8:5], er[k] / 10);
            chk("t3_col", v[4:1], er[k] % 10);
            chk("t3_pixel", v[0], 0);
        end
        if (rd_log.size() >= 27) begin
            chk("t3_col_step_a", rd_log[9], 3);
            chk("t3_col_step_b", rd_log[10], 8);
            chk("t3_col_step_c", rd_log[11], 13);
            chk("t3_row2_step_a", rd_log[24], 8);
            chk("t3_row2_step_b", rd_log[25], 13);
            chk("t3_row2_step_c", rd_log[26], 18);
        end

        // 5x4 textured image, first result held off for 20 cycles
        for (int a = 0; a < 20; a++) img[1][a] = 8'((a * 53 + (a / 5) * 97) % 256);
        ready[1] = 1'b0;
        kick(1);
        n = 0;
        while (!ov_w[1] && n < 100) begin
            step();
            n++;
        end
        chk("t4_first_valid", ov_w[1], 1);
        k0 = rd_log.size();
        repeat (20) step();
        chk("t4_no_reads_in_stall", rd_log.size(), k0);
        chk("t4_valid_after_stall", ov_w[1], 1);
        ready[1] = 1'b1;
        run_until_done(400);
        chk("t4_results", res_log.size(), 6);
        ref_log = res_log;

        // Same image with three wait cycles per read
        rd_delay = 3;
        kick(1);
        run_until_done(1000);
        rd_delay = 0;
        chk("t5_results", res_log.size(), ref_log.size());
        for (int k = 0; k < res_log.size() && k < ref_log.size(); k++)
            chk("t5_vs_zero_wait", res_log[k], ref_log[k]);

        // Asynchronous reset during CALC, then a clean rescan
        kick(1);
        repeat (15) step();
        n = 0;
        while (!en_w[1] && n < 200) begin
            step();
            n++;
        end
        chk("t6_reach_calc", en_w[1], 1);
        n_rst = 1'b0;
        #1;
        chk("t6_busy", busy_w[1], 0);
        chk("t6_sobel_en", en_w[1], 0);
        chk("t6_mem_read", rd_w[1], 0);
        chk("t6_out_valid", ov_w[1], 0);
        chk("t6_comp_matrix", int'(cm_w[1] != '0), 0);
        for (int k = 0; k < 3; k++) begin
            chk("t6_no_done", done_w[1], 0);
            @(negedge tb_clk);
        end
        n_rst = 1'b1;
        @(negedge tb_clk);
        chk("t6_idle_after_release", busy_w[1], 0);
        kick(1);
        run_until_done(400);
        chk("t6_results", res_log.size(), ref_log.size());
        for (int k = 0; k < res_log.size() && k < ref_log.size(); k++)
            chk("t6_vs_reference", res_log[k], ref_log[k]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
